// File: rtl/window_pkg.sv
// Shared helpers for the window pipeline: tap counting, accumulator sizing and identity-kernel values.
package window_pkg;

  function automatic int clog2_safe(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  function automatic int tap_count(input int ww, input int wh);
    return ww * wh;
  endfunction

  // Product width plus enough headroom that summing every tap cannot overflow.
  function automatic int acc_width(input int data_width, input int coeff_width, input int taps);
    return data_width + 1 + coeff_width + $clog2(taps);
  endfunction

  function automatic int centre_tap(input int ww, input int wh);
    return ((wh - 1) / 2) * ww + (ww - 1) / 2;
  endfunction

  function automatic int identity_coeff(input int tap, input int ww, input int wh, input int shift);
    return (tap == centre_tap(ww, wh)) ? (1 << shift) : 0;
  endfunction

endpackage

// File: rtl/window_kernel_mac_adder_tree.sv
// Registered pairwise reduction of N signed operands; one level per clock, odd leftovers ride along.
module adder_tree_pipelined #(
  parameter int N        = 9,
  parameter int IN_WIDTH = 17
) (
  input  logic                           clk_i,
  input  logic [N*IN_WIDTH-1:0]          data_i,
  output logic [IN_WIDTH+$clog2(N)-1:0]  sum_o
);

  localparam int LV = $clog2(N);
  localparam int OW = IN_WIDTH + LV;

  function automatic int level_count(input int lvl);
    return (N + (1 << lvl) - 1) >> lvl;
  endfunction

  logic [N*OW-1:0] ext;

  always_comb begin
    ext = '0;
    for (int i = 0; i < N; i++)
      ext[i*OW +: OW] = OW'(signed'(data_i[i*IN_WIDTH +: IN_WIDTH]));
  end

  generate
    if (LV == 0) begin : g_pass
      assign sum_o = ext;
    end else begin : g_tree
      logic [N*OW-1:0] lvl [1:LV];

      // Level 1 reads the sign-extended inputs; deeper levels read the previous register row.
      function automatic logic [OW-1:0] operand(input int l, input int j);
        int jj;
        jj = (j < N) ? j : 0;
        if (l == 1)
          return ext[jj*OW +: OW];
        return lvl[(l > 1) ? l - 1 : 1][jj*OW +: OW];
      endfunction

      always_ff @(posedge clk_i) begin
        for (int l = 1; l <= LV; l++) begin
          for (int i = 0; i < N; i++) begin
            if (i < level_count(l)) begin
              if (2*i + 1 < level_count(l - 1))
                lvl[l][i*OW +: OW] <= operand(l, 2*i) + operand(l, 2*i + 1);
              else
                lvl[l][i*OW +: OW] <= operand(l, 2*i);
            end else begin
              lvl[l][i*OW +: OW] <= '0;
            end
          end
        end
      end

      assign sum_o = lvl[LV][OW-1:0];
    end
  endgenerate

endmodule

// File: rtl/window_kernel_mac.sv
// Per-window multiply-accumulate with round/shift/saturate and a double-buffered kernel that
// only swaps on a frame-start beat, so one frame is never filtered with two kernels.
module window_kernel_mac
  import window_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int IMAGE_WIDTH   = 5,
  parameter int IMAGE_HEIGHT  = 5,
  parameter int WINDOW_WIDTH  = 3,
  parameter int WINDOW_HEIGHT = 3,
  parameter int COEFF_WIDTH   = 8,
  parameter int SHIFT         = 4,
  parameter int OUT_WIDTH     = 8,
  localparam int N  = tap_count(WINDOW_WIDTH, WINDOW_HEIGHT),
  localparam int CW = clog2_safe(IMAGE_WIDTH),
  localparam int RW = clog2_safe(IMAGE_HEIGHT),
  localparam int AW = clog2_safe(N)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N*DATA_WIDTH-1:0]  window_i,
  input  logic [CW-1:0]            col_i,
  input  logic [RW-1:0]            row_i,
  input  logic                     valid_i,
  input  logic                     coeff_we_i,
  input  logic [AW-1:0]            coeff_addr_i,
  input  logic [COEFF_WIDTH-1:0]   coeff_data_i,
  input  logic                     coeff_commit_i,
  output logic                     coeff_pending_o,
  output logic [OUT_WIDTH-1:0]     pixel_o,
  output logic [CW-1:0]            col_o,
  output logic [RW-1:0]            row_o,
  output logic                     valid_o
);

  localparam int LV      = $clog2(N);
  localparam int PW      = DATA_WIDTH + 1 + COEFF_WIDTH;
  localparam int ACC     = acc_width(DATA_WIDTH, COEFF_WIDTH, N);
  localparam int RND_INT = (SHIFT > 0) ? (1 << (SHIFT - 1)) : 0;
  localparam logic signed [ACC:0] OUT_MAX = (ACC+1)'({OUT_WIDTH{1'b1}});

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  logic [0:0]                    state;
  logic signed [COEFF_WIDTH-1:0] shadow_bank [N];
  logic signed [COEFF_WIDTH-1:0] active_bank [N];
  logic signed [PW-1:0]          pix_s [N];
  logic signed [PW-1:0]          coef_s [N];
  logic [N*PW-1:0]               prod;
  logic [ACC-1:0]                tree_sum;
  logic signed [ACC:0]           rounded;
  logic signed [ACC:0]           scaled;
  logic [OUT_WIDTH-1:0]          sat_pix;
  logic                          frame_start;
  logic                          swap;

  logic                          vld_pipe [LV+1];
  logic [CW-1:0]                 col_pipe [LV+1];
  logic [RW-1:0]                 row_pipe [LV+1];

  assign frame_start     = valid_i && (col_i == '0) && (row_i == '0);
  assign swap            = (state == ST_PENDING) && frame_start;
  assign coeff_pending_o = (state == ST_PENDING);

  // Shadow edits are frozen while a swap is armed so the committed kernel is exactly what lands.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= ST_IDLE;
      for (int i = 0; i < N; i++) begin
        shadow_bank[i] <= COEFF_WIDTH'(identity_coeff(i, WINDOW_WIDTH, WINDOW_HEIGHT, SHIFT));
        active_bank[i] <= COEFF_WIDTH'(identity_coeff(i, WINDOW_WIDTH, WINDOW_HEIGHT, SHIFT));
      end
    end else if (state == ST_IDLE) begin
      if (coeff_we_i && (int'(coeff_addr_i) < N))
        shadow_bank[coeff_addr_i] <= coeff_data_i;
      if (coeff_commit_i)
        state <= ST_PENDING;
    end else if (frame_start) begin
      active_bank <= shadow_bank;
      state       <= ST_IDLE;
    end
  end

  // The frame-start beat that triggers the swap is multiplied by the incoming kernel.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      pix_s[i]  = PW'(signed'({1'b0, window_i[i*DATA_WIDTH +: DATA_WIDTH]}));
      coef_s[i] = PW'(swap ? shadow_bank[i] : active_bank[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < N; i++)
      prod[i*PW +: PW] <= pix_s[i] * coef_s[i];
  end

  adder_tree_pipelined #(
    .N        (N),
    .IN_WIDTH (PW)
  ) u_tree (
    .clk_i  (clk_i),
    .data_i (prod),
    .sum_o  (tree_sum)
  );

  // One extra bit keeps the rounding constant from wrapping a near-full-scale sum.
  always_comb begin
    rounded = (ACC+1)'(signed'(tree_sum)) + (ACC+1)'(RND_INT);
    scaled  = rounded >>> SHIFT;
    if (scaled[ACC])
      sat_pix = '0;
    else if (scaled > OUT_MAX)
      sat_pix = '1;
    else
      sat_pix = scaled[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int k = 0; k <= LV; k++) begin
        vld_pipe[k] <= 1'b0;
        col_pipe[k] <= '0;
        row_pipe[k] <= '0;
      end
      valid_o <= 1'b0;
      pixel_o <= '0;
      col_o   <= '0;
      row_o   <= '0;
    end else begin
      vld_pipe[0] <= valid_i;
      col_pipe[0] <= col_i;
      row_pipe[0] <= row_i;
      for (int k = 1; k <= LV; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        col_pipe[k] <= col_pipe[k-1];
        row_pipe[k] <= row_pipe[k-1];
      end
      valid_o <= vld_pipe[LV];
      // Coordinates and pixel hold their last valid values across idle beats.
      if (vld_pipe[LV]) begin
        pixel_o <= sat_pix;
        col_o   <= col_pipe[LV];
        row_o   <= row_pipe[LV];
      end
    end
  end

endmodule

// File: tb/tb_window_kernel_mac.sv
// Randomized bench for window_kernel_mac: a spec-level kernel/bank model predicts every output beat.
module tb_window_kernel_mac;

  localparam int N      = 9;
  localparam int LAT    = 6;
  localparam int CENTRE = 4;

  typedef struct {
    bit    valid;
    int    pixel;
    int    col;
    int    row;
    int    want;
    string tag;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [71:0]   window_i;
  logic [2:0]    col_i;
  logic [2:0]    row_i;
  logic          valid_i;
  logic          coeff_we_i;
  logic [3:0]    coeff_addr_i;
  logic [7:0]    coeff_data_i;
  logic          coeff_commit_i;
  logic          coeff_pending_o;
  logic [7:0]    pixel_o;
  logic [2:0]    col_o;
  logic [2:0]    row_o;
  logic          valid_o;

  int    shadow_m [N];
  int    active_m [N];
  bit    pending_m;
  exp_t  exp_q [$];
  int    last_col, last_row;
  int    total, bad;
  int    want_next;
  string want_tag;
  bit    pixel_zero_chk;
  int    obs_valid, exp_valid;
  int    run_len, best_run;

  always #5 clk_i = ~clk_i;

  window_kernel_mac #(
    .DATA_WIDTH    (8),
    .IMAGE_WIDTH   (5),
    .IMAGE_HEIGHT  (5),
    .WINDOW_WIDTH  (3),
    .WINDOW_HEIGHT (3),
    .COEFF_WIDTH   (8),
    .SHIFT         (4),
    .OUT_WIDTH     (8)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .window_i        (window_i),
    .col_i           (col_i),
    .row_i           (row_i),
    .valid_i         (valid_i),
    .coeff_we_i      (coeff_we_i),
    .coeff_addr_i    (coeff_addr_i),
    .coeff_data_i    (coeff_data_i),
    .coeff_commit_i  (coeff_commit_i),
    .coeff_pending_o (coeff_pending_o),
    .pixel_o         (pixel_o),
    .col_o           (col_o),
    .row_o           (row_o),
    .valid_o         (valid_o)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed != expected) begin
      bad++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Convolution straight from the definition: weighted sum, round half up, floor-divide, clamp.
  function automatic int expected_pixel(input logic [71:0] win, input bit use_shadow);
    int acc;
    int q;
    acc = 0;
    for (int i = 0; i < N; i++)
      acc += int'(win[i*8 +: 8]) * (use_shadow ? shadow_m[i] : active_m[i]);
    acc += 8;
    q = (acc >= 0) ? acc / 16 : -((-acc + 15) / 16);
    if (q < 0)   q = 0;
    if (q > 255) q = 255;
    return q;
  endfunction

  task automatic reset_model();
    exp_t e;
    e.valid = 1'b0; e.pixel = 0; e.col = 0; e.row = 0; e.want = -1; e.tag = "";
    for (int i = 0; i < N; i++) begin
      shadow_m[i] = (i == CENTRE) ? 16 : 0;
      active_m[i] = (i == CENTRE) ? 16 : 0;
    end
    pending_m = 1'b0;
    exp_q.delete();
    repeat (LAT) exp_q.push_back(e);
    last_col = 0;
    last_row = 0;
    pixel_zero_chk = 1'b1;
  endtask

  task automatic check_cycle();
    exp_t e;
    checkOutput("pending", int'(coeff_pending_o), int'(pending_m));
    if (pixel_zero_chk) begin
      checkOutput("reset_pixel", int'(pixel_o), 0);
      pixel_zero_chk = 1'b0;
    end
    if (valid_o) begin
      obs_valid++;
      run_len++;
      if (run_len > best_run) best_run = run_len;
    end else begin
      run_len = 0;
    end
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    checkOutput("valid", int'(valid_o), int'(e.valid));
    if (e.valid) begin
      exp_valid++;
      checkOutput("pixel", int'(pixel_o), e.pixel);
      checkOutput("col", int'(col_o), e.col);
      checkOutput("row", int'(row_o), e.row);
      last_col = e.col;
      last_row = e.row;
      if (e.want >= 0) checkOutput(e.tag, int'(pixel_o), e.want);
    end else begin
      checkOutput("col_hold", int'(col_o), last_col);
      checkOutput("row_hold", int'(row_o), last_row);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit valid, input int col, input int row,
                               input logic [71:0] win, input bit we, input int addr,
                               input int data, input bit commit);
    exp_t e;
    bit   fs;
    @(negedge clk_i);
    check_cycle();
    rst_i          = ~rst;
    valid_i        = valid;
    col_i          = 3'(col);
    row_i          = 3'(row);
    window_i       = win;
    coeff_we_i     = we;
    coeff_addr_i   = 4'(addr);
    coeff_data_i   = 8'(data);
    coeff_commit_i = commit;
    if (rst) begin
      reset_model();
      want_next = -1;
      return;
    end
    fs      = valid && (col == 0) && (row == 0);
    e.valid = valid;
    e.col   = col;
    e.row   = row;
    e.want  = want_next;
    e.tag   = want_tag;
    e.pixel = valid ? expected_pixel(win, pending_m && fs) : 0;
    want_next = -1;
    if (pending_m && fs) begin
      active_m  = shadow_m;
      pending_m = 1'b0;
    end else if (!pending_m) begin
      if (we && addr < N) shadow_m[addr] = int'($signed(8'(data)));
      if (commit) pending_m = 1'b1;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 0, 0, '0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic send_beat(input int col, input int row, input logic [71:0] win, input bit commit);
    applyStimulus(1'b0, 1'b1, col, row, win, 1'b0, 0, 0, commit);
  endtask

  task automatic write_coeff(input int addr, input int data, input bit commit);
    applyStimulus(1'b0, 1'b0, 0, 0, '0, 1'b1, addr, data, commit);
  endtask

  function automatic logic [71:0] fill_window(input logic [7:0] v);
    return {9{v}};
  endfunction

  function automatic logic [71:0] rand_window();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic send_frame(input bit commit_mid);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        send_beat(c, r, rand_window(), commit_mid && (r == 2) && (c == 0));
  endtask

  task automatic load_random_kernel(input bit commit);
    for (int i = 0; i < N; i++)
      write_coeff(i, int'($urandom_range(0, 255)), commit && (i == N - 1));
  endtask

  initial begin
    logic [71:0] w;
    int          v;
    total = 0; bad = 0; obs_valid = 0; exp_valid = 0; run_len = 0; best_run = 0;
    want_next = -1; want_tag = "";
    rst_i = 1'b0; valid_i = 1'b0; col_i = '0; row_i = '0; window_i = '0;
    coeff_we_i = 1'b0; coeff_addr_i = '0; coeff_data_i = '0; coeff_commit_i = 1'b0;
    reset_model();
    repeat (2) applyStimulus(1'b1, 1'b0, 0, 0, '0, 1'b0, 0, 0, 1'b0);

    // Identity kernel straight out of reset passes the centre pixel through.
    w = fill_window(8'h11);
    w[CENTRE*8 +: 8] = 8'h5A;
    want_next = 90; want_tag = "identity";
    send_beat(2, 3, w, 1'b0);
    idle_cycles(8);

    // Box filter, last write shares its cycle with the commit.
    for (int i = 0; i < N - 1; i++) write_coeff(i, 1, 1'b0);
    write_coeff(N - 1, 1, 1'b1);
    idle_cycles(2);
    want_next = 9; want_tag = "box";
    send_beat(0, 0, fill_window(8'd16), 1'b0);
    idle_cycles(8);

    // Saturation at both ends.
    for (int i = 0; i < N; i++) write_coeff(i, 16, i == N - 1);
    want_next = 255; want_tag = "sat_high";
    send_beat(0, 0, fill_window(8'd255), 1'b0);
    idle_cycles(2);
    for (int i = 0; i < N; i++) write_coeff(i, (i == CENTRE) ? -16 : 0, i == N - 1);
    w = rand_window();
    w[CENTRE*8 +: 8] = 8'd100;
    want_next = 0; want_tag = "sat_low";
    send_beat(0, 0, w, 1'b0);
    idle_cycles(8);

    // Commit mid-frame; next frame picks the new kernel and streams contiguously.
    load_random_kernel(1'b0);
    send_frame(1'b1);
    idle_cycles(8);
    run_len = 0; best_run = 0;
    send_frame(1'b0);
    idle_cycles(8);
    checkOutput("contiguous", best_run, 25);

    // Pending rules: dropped writes, ignored address, commit on a frame-start beat.
    write_coeff(12, 99, 1'b0);
    write_coeff(4, 5, 1'b1);
    write_coeff(4, 77, 1'b0);
    write_coeff(3, 33, 1'b1);
    send_beat(0, 0, rand_window(), 1'b0);
    idle_cycles(3);
    write_coeff(0, 40, 1'b0);
    send_beat(0, 0, rand_window(), 1'b1);
    send_beat(1, 0, rand_window(), 1'b0);
    send_beat(2, 0, rand_window(), 1'b0);
    send_beat(0, 0, rand_window(), 1'b0);
    idle_cycles(8);

    // Reset with a full pipeline: every beat dropped, identity back in force.
    load_random_kernel(1'b1);
    send_beat(0, 0, rand_window(), 1'b0);
    for (int c = 1; c < 5; c++) send_beat(c, 0, rand_window(), 1'b0);
    send_beat(0, 1, rand_window(), 1'b0);
    repeat (2) applyStimulus(1'b1, 1'b1, 1, 1, rand_window(), 1'b1, 2, 50, 1'b1);
    idle_cycles(8);
    w = rand_window();
    v = int'(w[CENTRE*8 +: 8]);
    want_next = v; want_tag = "post_reset_identity";
    send_beat(1, 1, w, 1'b0);
    idle_cycles(8);

    // Random traffic mixing beats, frame starts, writes, commits and occasional resets.
    for (int n = 0; n < 300; n++) begin
      bit rst, valid, we, commit;
      int col, row;
      rst    = ($urandom_range(0, 99) < 2);
      valid  = ($urandom_range(0, 99) < 70);
      we     = ($urandom_range(0, 99) < 15);
      commit = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 9) == 0) begin
        col = 0; row = 0;
      end else begin
        col = int'($urandom_range(0, 4));
        row = int'($urandom_range(0, 4));
      end
      applyStimulus(rst, valid, col, row, rand_window(), we,
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), commit);
    end
    idle_cycles(8);
    checkOutput("valid_count", obs_valid, exp_valid);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
